// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and FSM state type.
package aes_pkg;

  localparam int unsigned NB   = 4;
  localparam int unsigned RK_W = 128;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} aes_fsm_e;

  // Forward S-box; entry x is at index x (entry 0 in the MSBs).
  localparam logic [0:255][7:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by {02} in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns; row 0 byte in the MSBs.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r of the state rotates left by r columns; byte 4c+r is row r, column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES forward S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = AES_SBOX[i_byte];

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core: one round per clock, expanded key supplied by the caller.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int unsigned nk = 8,
  parameter int unsigned nb = 4,
  parameter int unsigned nr = 14
) (
  input  logic                          in_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [32*nb-1:0]              in_msg,
  input  logic [32*nb*(nr+1)-1:0]       in_key,
  output logic [32*nb-1:0]              out_msg,
  output logic                          done,
  output logic                          busy
);

  localparam int unsigned ST_W  = 32 * nb;
  localparam int unsigned KEY_W = 32 * nb * (nr + 1);
  localparam int unsigned RW    = $clog2(nr + 1);

  if ((nk != 4 && nk != 6 && nk != 8) || nr != nk + 6 || nb != NB) begin : g_bad_cfg
    $error("aes_iter_cipher: illegal nk/nb/nr combination");
  end

  aes_fsm_e           r_fsm;
  logic [ST_W-1:0]    r_state;
  logic [RW-1:0]      r_round;
  logic               r_start_d;
  logic [ST_W-1:0]    r_out;
  logic               r_done;
  logic               r_busy;

  logic [RK_W-1:0]    w_rk [nr+1];
  logic [ST_W-1:0]    w_sub;
  logic [ST_W-1:0]    w_shift;
  logic [ST_W-1:0]    w_mix;
  logic [RK_W-1:0]    w_rk_cur;
  logic               w_trigger;

  // Split the expanded key into round keys, round key 0 from the MSBs.
  for (genvar i = 0; i <= nr; i++) begin : g_rk
    assign w_rk[i] = in_key[KEY_W-1-RK_W*i -: RK_W];
  end

  // SubBytes: sixteen parallel S-box lookups on the current state.
  for (genvar n = 0; n < 16; n++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (r_state[ST_W-1-8*n -: 8]),
      .o_byte (w_sub[ST_W-1-8*n -: 8])
    );
  end

  assign w_shift = shift_rows(w_sub);

  // MixColumns applied column by column.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mix[ST_W-1-32*c -: 32] = mix_column(w_shift[ST_W-1-32*c -: 32]);
  end

  assign w_rk_cur  = w_rk[r_round];
  assign w_trigger = start && !r_start_d;

  // Round sequencer: initial AddRoundKey on trigger, nr rounds, final round skips MixColumns.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= IDLE;
      r_state   <= '0;
      r_round   <= '0;
      r_start_d <= 1'b0;
      r_out     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_start_d <= start;
      r_done    <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_trigger) begin
            r_state <= in_msg ^ w_rk[0];
            r_round <= RW'(1);
            r_busy  <= 1'b1;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          if (r_round == RW'(nr)) begin
            r_out  <= w_shift ^ w_rk_cur;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_fsm  <= IDLE;
          end else begin
            r_state <= w_mix ^ w_rk_cur;
            r_round <= r_round + RW'(1);
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign out_msg = r_out;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Directed bench for aes_iter_cipher: FIPS-197 vectors plus control corner cases.
module tb_aes_iter_cipher;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  logic          in_clk;
  logic          rst;
  logic          start, start128;
  logic [127:0]  in_msg, in_msg128;
  logic [1919:0] in_key;
  logic [1407:0] in_key128;
  logic [127:0]  out256, out128;
  logic          done256, done128, busy256, busy128;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]    sb [256];
  logic [1919:0] ek_full128;

  aes_iter_cipher u_dut256 (
    .in_clk (in_clk), .rst (rst), .start (start), .in_msg (in_msg),
    .in_key (in_key), .out_msg (out256), .done (done256), .busy (busy256)
  );

  aes_iter_cipher #(.nk(4), .nb(4), .nr(10)) u_dut128 (
    .in_clk (in_clk), .rst (rst), .start (start128), .in_msg (in_msg128),
    .in_key (in_key128), .out_msg (out128), .done (done128), .busy (busy128)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box derived from the field inverse and affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Key schedule; key MSB-aligned, result MSB-aligned in 1920 bits.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nkk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] ek;
    int            nw;
    nw = 4 * (nkk + 7);
    rcon = 8'h01;
    for (int i = 0; i < nkk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nkk; i < nw; i++) begin
      t = w[i-1];
      if (i % nkk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nkk > 6 && i % nkk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nkk] ^ t;
    end
    ek = '0;
    for (int i = 0; i < nw; i++) ek[1919-32*i -: 32] = w[i];
    return ek;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [1919:0] ek, input int nrr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ ek[1919-8*n -: 8];
    for (int r = 1; r <= nrr; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r != nrr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ ek[1919-128*r-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  // Watch a DUT for a fixed number of cycles; lat counts edges after the trigger edge.
  task automatic mon(input bit sel, input int budget, output int lat, output int npulse, output int nbusy);
    lat = -1; npulse = 0; nbusy = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge in_clk);
      if (sel ? done128 : done256) begin
        npulse++;
        if (lat < 0) lat = k - 1;
      end
      if (sel ? busy128 : busy256) nbusy++;
    end
  endtask

  initial begin
    int lat, np, nbz, hold_bad;
    logic [127:0] exp2;
    rst = 1'b0; start = 1'b0; start128 = 1'b0;
    in_msg = PT1; in_msg128 = PT1;
    build_sbox();
    in_key = expand(K256, 8);
    ek_full128 = expand(K128, 4);
    in_key128 = ek_full128[1919 -: 1408];
    exp2 = model_enc(PT2, in_key, 14);

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_out", out256, 128'h0);
    check("rst_done", 128'(done256), 128'h0);
    check("rst_busy", 128'(busy256), 128'h0);
    check("rst_out128", out128, 128'h0);
    @(negedge in_clk); @(negedge in_clk);
    rst = 1'b0;
    @(negedge in_clk);

    // AES-256 C.3
    start = 1'b1;
    mon(1'b0, 30, lat, np, nbz);
    check("c3_lat", 128'(lat), 128'(14));
    check("c3_pulses", 128'(np), 128'(1));
    check("c3_busy_cycles", 128'(nbz), 128'(14));
    check("c3_out", out256, C3);

    // start held high does not retrigger
    mon(1'b0, 40, lat, np, nbz);
    check("held_pulses", 128'(np), 128'(0));
    check("held_out", out256, C3);

    // AES-128 C.1
    start128 = 1'b1;
    mon(1'b1, 20, lat, np, nbz);
    check("c1_lat", 128'(lat), 128'(10));
    check("c1_pulses", 128'(np), 128'(1));
    check("c1_out", out128, C1);

    // reset at round 7 aborts
    start = 1'b0;
    @(negedge in_clk);
    start = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge in_clk);
    rst = 1'b1;
    #1;
    check("abort_out", out256, 128'h0);
    check("abort_done", 128'(done256), 128'h0);
    check("abort_busy", 128'(busy256), 128'h0);
    start = 1'b0;
    @(negedge in_clk);
    rst = 1'b0;
    mon(1'b0, 30, lat, np, nbz);
    check("abort_no_done", 128'(np), 128'(0));
    check("abort_no_busy", 128'(nbz), 128'(0));

    // fresh trigger, then back-to-back trigger on the done cycle
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge in_clk);
      if (k == 2) start = 1'b0;
      if (done256) begin
        lat = k - 1;
        start = 1'b1;
        in_msg = PT2;
      end
    end
    check("fresh_lat", 128'(lat), 128'(14));
    check("fresh_out", out256, C3);
    lat = -1; hold_bad = 0;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge in_clk);
      if (done256) lat = k - 1;
      else if (out256 !== C3) hold_bad++;
    end
    check("b2b_lat", 128'(lat), 128'(14));
    check("b2b_hold", 128'(hold_bad), 128'(0));
    check("b2b_out", out256, exp2);

    // retrigger at round 5 is ignored
    @(negedge in_clk);
    start = 1'b0;
    in_msg = PT1;
    @(negedge in_clk);
    start = 1'b1;
    lat = -1; np = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge in_clk);
      if (k == 5) start = 1'b0;
      if (k == 6) begin
        start = 1'b1;
        in_msg = PT2;
      end
      if (done256) begin
        np++;
        if (lat < 0) lat = k - 1;
      end
    end
    check("retrig_lat", 128'(lat), 128'(14));
    check("retrig_pulses", 128'(np), 128'(1));
    check("retrig_out", out256, C3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
